rtl_dcnt_p: RTL

- N-bit down counter with borrow-in and borrow-out. It is the decrementing counterpart of the team's up counter: `bin` plays the role of `cin`, and `bout` plays the role of `cout`.
- The borrow chain is segmented. Each segment registers an "all-zero" flag, so the critical path is bounded by SEG bits plus an AND over the segment flags, not by N.
- Externally the block is cycle-exact equivalent to a flat behavioural down counter. A bench compares the two in lockstep.

---
 rtl/cnt_pkg.sv | 15 +
 rtl/rtl_dcnt_seg.sv | 35 +++
 rtl/rtl_dcnt_p.sv | 52 +++++
 3 files changed

// File: rtl/cnt_pkg.sv
// Width helpers shared by the segmented up and down counters.
package cnt_pkg;

    function automatic int nseg(input int n, input int seg);
        return (n + seg - 1) / seg;
    endfunction

    // The top segment takes whatever bits remain after the full-width ones.
    function automatic int segw(input int k, input int n, input int seg);
        int ns;
        ns = nseg(n, seg);
        return (k == ns - 1) ? (n - (ns - 1) * seg) : seg;
    endfunction

endpackage

// File: rtl/rtl_dcnt_seg.sv
// One slice of the segmented down counter: W-bit register plus a registered
// zero flag derived only from this slice's next value.
module rtl_dcnt_seg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         bin_seg,
    input  logic         ld,
    input  logic [W-1:0] din_seg,
    output logic [W-1:0] q,
    output logic         z
);

    logic [W-1:0] qn;

    always_comb begin
        qn = q;
        if (ld)
            qn = din_seg;
        else if (bin_seg)
            qn = q - W'(1);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            q <= '0;
            z <= 1'b1;
        end else begin
            q <= qn;
            z <= (qn == '0);
        end
    end

endmodule

// File: rtl/rtl_dcnt_p.sv
// N-bit down counter with borrow-in/out; the borrow chain runs through
// registered per-segment zero flags so the carry path stays SEG bits deep.
module rtl_dcnt_p
    import cnt_pkg::*;
#(
    parameter int N   = 17,
    parameter int SEG = 4
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         bin,
    input  logic         ld,
    input  logic [N-1:0] din,
    output logic [N-1:0] cnt,
    output logic         bout
);

    localparam int NS = nseg(N, SEG);

    logic [NS-1:0] zf;
    logic [NS-1:0] bseg;

    // Borrow into segment k needs every lower segment to be zero.
    always_comb begin
        bseg    = '0;
        bseg[0] = bin;
        for (int k = 1; k < NS; k++)
            bseg[k] = bseg[k-1] & zf[k-1];
    end

    for (genvar k = 0; k < NS; k++) begin : g_seg
        localparam int W  = segw(k, N, SEG);
        localparam int LO = k * SEG;
        rtl_dcnt_seg #(.W(W)) u_seg (
            .clk     (clk),
            .nreset  (nreset),
            .bin_seg (bseg[k]),
            .ld      (ld),
            .din_seg (din[LO +: W]),
            .q       (cnt[LO +: W]),
            .z       (zf[k])
        );
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)
            bout <= 1'b0;
        else
            bout <= ~ld & bin & (&zf);
    end

endmodule
